// File: rtl/in_flight_issue_arbiter_pkg.sv
// Shared defaults and width helper for the in-flight issue arbiter and its picker.
// Optional simulation checks in the top are enabled with IN_FLIGHT_ARB_ASSERT_EN.
package in_flight_issue_arbiter_pkg;

    localparam int COLORS_DEFAULT    = 4;
    localparam int MIN_DEPTH_DEFAULT = 32;
    localparam int MAX_DEPTH_DEFAULT = 512;

    // Ceiling log2, never below 1 so a single-bit field is always legal.
    function automatic int log2(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) < value) bits++;
        return bits;
    endfunction

endpackage

// File: rtl/in_flight_issue_arbiter_if.sv
// Request, memory-issue and response-retire signals of the in-flight issue arbiter.
// master = requesters/memory side, slave = arbiter.
interface in_flight_issue_arbiter_if
    import in_flight_issue_arbiter_pkg::*;
#(
    parameter int COLORS    = COLORS_DEFAULT,
    parameter int MAX_DEPTH = MAX_DEPTH_DEFAULT
);
    localparam int LOG2_COLORS    = log2(COLORS);
    localparam int LOG2_MAX_DEPTH = log2(MAX_DEPTH);

    logic [COLORS-1:0]      req_valid;
    logic [COLORS-1:0]      req_ready;
    logic                   mem_stall;
    logic                   mem_push;
    logic [LOG2_COLORS-1:0] mem_tag;
    logic                   rsp_valid;
    logic [LOG2_COLORS-1:0] rsp_tag;
    logic [LOG2_MAX_DEPTH:0] total;
    logic                   err;

    modport master (
        output req_valid, mem_stall, rsp_valid, rsp_tag,
        input  req_ready, mem_push, mem_tag, total, err
    );

    modport slave (
        input  req_valid, mem_stall, rsp_valid, rsp_tag,
        output req_ready, mem_push, mem_tag, total, err
    );

endinterface

// File: rtl/in_flight_issue_arbiter_rr_priority_pick.sv
// Combinational rotate-priority picker: first eligible bit at or above rr_ptr, with wrap.
// Output is one-hot or zero; reusable by other arbiters.
module rr_priority_pick
    import in_flight_issue_arbiter_pkg::*;
#(
    parameter int COLORS = COLORS_DEFAULT
) (
    input  logic [COLORS-1:0]       eligible,
    input  logic [log2(COLORS)-1:0] rr_ptr,
    output logic [COLORS-1:0]       grant
);
    localparam int LW = log2(COLORS);

    logic          found;
    logic [LW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < COLORS; i++) begin
            idx = LW'((int'(rr_ptr) + i) % COLORS);
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/in_flight_issue_arbiter.sv
// Credit-based round-robin arbiter: per-color reserved slots plus a shared head-room pool.
// Define IN_FLIGHT_ARB_ASSERT_EN to compile in simulation sanity checks.
module in_flight_issue_arbiter
    import in_flight_issue_arbiter_pkg::*;
#(
    parameter int COLORS    = COLORS_DEFAULT,
    parameter int MIN_DEPTH = MIN_DEPTH_DEFAULT,
    parameter int MAX_DEPTH = MAX_DEPTH_DEFAULT
) (
    input logic                      clk,
    input logic                      rst,
    in_flight_issue_arbiter_if.slave bus
);
    localparam int HEAD_ROOM      = MAX_DEPTH - COLORS * MIN_DEPTH;
    localparam int LOG2_COLORS    = log2(COLORS);
    localparam int LOG2_MAX_DEPTH = log2(MAX_DEPTH);
    localparam int CW             = LOG2_MAX_DEPTH + 1;

    localparam logic [CW-1:0] MIN_W       = CW'(MIN_DEPTH);
    localparam logic [CW-1:0] MAX_W       = CW'(MAX_DEPTH);
    localparam logic [CW-1:0] HEAD_ROOM_W = CW'(HEAD_ROOM);

    logic [CW-1:0]          count_q [COLORS];
    logic [CW-1:0]          shared_q;
    logic [CW-1:0]          total_q;
    logic [LOG2_COLORS-1:0] rr_ptr_q;
    logic                   mem_push_q;
    logic [LOG2_COLORS-1:0] mem_tag_q;
    logic                   err_q;

    logic [COLORS-1:0]      eligible;
    logic [COLORS-1:0]      grant;
    logic [LOG2_COLORS-1:0] grant_idx;
    logic [LOG2_COLORS-1:0] rr_next;
    logic                   issue;
    logic                   retire_ok;
    logic                   retire_bad;
    logic                   same_color;
    logic                   shared_inc;
    logic                   shared_dec;

    // Eligibility looks only at registered state, so a same-cycle retire cannot unblock.
    always_comb begin
        eligible = '0;
        for (int c = 0; c < COLORS; c++) begin
            eligible[c] = bus.req_valid[c] & ~bus.mem_stall & (total_q < MAX_W) &
                          ((count_q[c] < MIN_W) | (shared_q < HEAD_ROOM_W));
        end
    end

    rr_priority_pick #(.COLORS(COLORS)) u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_q),
        .grant    (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int c = 0; c < COLORS; c++) begin
            if (grant[c]) grant_idx = LOG2_COLORS'(c);
        end
    end

    assign issue      = |grant;
    assign rr_next    = (grant_idx == LOG2_COLORS'(COLORS - 1)) ? '0 : grant_idx + LOG2_COLORS'(1);
    assign retire_ok  = bus.rsp_valid & (count_q[bus.rsp_tag] != '0);
    assign retire_bad = bus.rsp_valid & (count_q[bus.rsp_tag] == '0);
    // Issue and retire on one color cancel completely, including the shared pool.
    assign same_color = issue & retire_ok & (grant_idx == bus.rsp_tag);
    assign shared_inc = issue & ~same_color & (count_q[grant_idx] >= MIN_W);
    assign shared_dec = retire_ok & ~same_color & (count_q[bus.rsp_tag] > MIN_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < COLORS; c++) count_q[c] <= '0;
            shared_q   <= '0;
            total_q    <= '0;
            rr_ptr_q   <= '0;
            mem_push_q <= 1'b0;
            mem_tag_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            mem_push_q <= issue;
            if (issue) begin
                mem_tag_q <= grant_idx;
                rr_ptr_q  <= rr_next;
            end
            if (retire_bad) err_q <= 1'b1;
            if (!same_color) begin
                if (issue)     count_q[grant_idx]   <= count_q[grant_idx] + CW'(1);
                if (retire_ok) count_q[bus.rsp_tag] <= count_q[bus.rsp_tag] - CW'(1);
            end
            shared_q <= shared_q + CW'(shared_inc) - CW'(shared_dec);
            total_q  <= total_q + CW'(issue) - CW'(retire_ok);
        end
    end

    assign bus.req_ready = grant;
    assign bus.mem_push  = mem_push_q;
    assign bus.mem_tag   = mem_tag_q;
    assign bus.total     = total_q;
    assign bus.err       = err_q;

`ifdef IN_FLIGHT_ARB_ASSERT_EN
    always @(posedge clk) begin
        if (!rst) begin
            if ($countones(grant) > 1) begin
                $display("in_flight_issue_arbiter: error, req_ready not one-hot: %b", grant);
                $finish;
            end
            for (int c = 0; c < COLORS; c++) begin
                if (count_q[c] > CW'(MIN_DEPTH + HEAD_ROOM)) begin
                    $display("in_flight_issue_arbiter: error, count[%0d]=%0d over bound", c, count_q[c]);
                    $finish;
                end
            end
            if (total_q > MAX_W || shared_q > HEAD_ROOM_W) begin
                $display("in_flight_issue_arbiter: error, total=%0d shared=%0d over bound", total_q, shared_q);
                $finish;
            end
            if (retire_bad && !err_q) begin
                $display("in_flight_issue_arbiter: error, retire on empty color %0d", bus.rsp_tag);
                $finish;
            end
        end
    end
`else
    // Checks compiled out; err is still produced above.
`endif

endmodule
